// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between execute (p4) and write-back (p5).
// Latency: non-memory ops reach p5 in 1 cycle; memory ops reach p5 on the edge after ack or timeout.
// Backpressure: stall_mem_p4 holds upstream from issue until the ack (or timeout) cycle; memory side is req/ack.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd-address loads/stores
// with an error pulse instead of issuing them.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   *_ixmem_p4, pc_p4           - op presented by execute, held while stall_mem_p4 is high
//   dmem_req/we/addr/wdata      - memory request, held stable until ack or timeout
//   dmem_rdata, dmem_ack        - memory response; rdata valid with ack
//   stall_mem_p4                - hold upstream
//   wb_*_mewb_p5, err_mem_p5,
//   pc_p5                       - registered write-back outputs (all zero for bubbles)
module mem_stage #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_p4,
  input  logic [15:0] dest_reg_value_ixmem_p4,
  input  logic [2:0]  dest_reg_index_ixmem_p4,
  input  logic        dest_reg_write_valid_ixmem_p4,
  input  logic [15:0] mem_addr_ixmem_p4,
  input  logic        ldst_valid_ixmem_p4,
  input  logic [1:0]  store_valid_ixmem_p4,
  input  logic [15:0] mem_data_in_ixmem_p4,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem_p4,
  output logic [15:0] wb_value_mewb_p5,
  output logic [2:0]  wb_index_mewb_p5,
  output logic        wb_write_valid_mewb_p5,
  output logic        err_mem_p5,
  output logic [15:0] pc_p5
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  // Op captured at issue; upstream also holds it, but the stage owns its copy.
  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  idx;
    logic [15:0] pc;
  } op_t;

  state_t      state, state_n;
  op_t         op_q, op_n;
  logic [7:0]  cnt, cnt_n;
  logic        req_n, we_n;
  logic [15:0] addr_n, wdata_n;
  logic [15:0] wb_val_n, pc5_n;
  logic [2:0]  wb_idx_n;
  logic        wb_wv_n, err_n;
  logic        timeout_hit;
  logic        misalign;
  logic [15:0] rd_val;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ldst_valid_ixmem_p4 & mem_addr_ixmem_p4[0];
`else
  assign misalign = 1'b0;
`endif

  // Last WAIT cycle without ack: this edge abandons the access.
  assign timeout_hit = (state == S_WAIT) && !dmem_ack && (cnt == TO_LAST);
  assign rd_val      = dmem_ack ? dmem_rdata : 16'h0000;

  always_comb begin
    state_n      = state;
    op_n         = op_q;
    cnt_n        = cnt;
    req_n        = dmem_req;
    we_n         = dmem_we;
    addr_n       = dmem_addr;
    wdata_n      = dmem_wdata;
    wb_val_n     = 16'h0000;
    wb_idx_n     = 3'd0;
    wb_wv_n      = 1'b0;
    err_n        = 1'b0;
    pc5_n        = 16'h0000;
    stall_mem_p4 = 1'b0;

    case (state)
      S_IDLE: begin
        // dmem_ack is deliberately not looked at here.
        if (misalign) begin
          wb_idx_n = dest_reg_index_ixmem_p4;
          err_n    = 1'b1;
          pc5_n    = pc_p4;
        end else if (ldst_valid_ixmem_p4) begin
          stall_mem_p4 = 1'b1;
          state_n      = S_WAIT;
          req_n        = 1'b1;
          we_n         = (store_valid_ixmem_p4 != 2'b00);
          addr_n       = mem_addr_ixmem_p4;
          wdata_n      = mem_data_in_ixmem_p4;
          op_n.kind    = store_valid_ixmem_p4;
          op_n.idx     = dest_reg_index_ixmem_p4;
          op_n.pc      = pc_p4;
          cnt_n        = 8'd0;
        end else begin
          wb_val_n = dest_reg_value_ixmem_p4;
          wb_idx_n = dest_reg_index_ixmem_p4;
          wb_wv_n  = dest_reg_write_valid_ixmem_p4;
          pc5_n    = pc_p4;
        end
      end
      S_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          // Stall also drops on a timeout edge so upstream retires the op
          // instead of re-issuing it from IDLE.
          state_n  = S_IDLE;
          req_n    = 1'b0;
          cnt_n    = 8'd0;
          wb_idx_n = op_q.idx;
          pc5_n    = op_q.pc;
          err_n    = timeout_hit;
          case (op_q.kind)
            2'b00: begin wb_val_n = rd_val;    wb_wv_n = 1'b1; end
            2'b10: begin wb_val_n = dmem_addr; wb_wv_n = 1'b1; end
            default: begin wb_val_n = 16'h0000; wb_wv_n = 1'b0; end
          endcase
        end else begin
          stall_mem_p4 = 1'b1;
          cnt_n        = cnt + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (rst) stall_mem_p4 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      op_q                   <= '0;
      cnt                    <= 8'd0;
      dmem_req               <= 1'b0;
      dmem_we                <= 1'b0;
      dmem_addr              <= 16'h0000;
      dmem_wdata             <= 16'h0000;
      wb_value_mewb_p5       <= 16'h0000;
      wb_index_mewb_p5       <= 3'd0;
      wb_write_valid_mewb_p5 <= 1'b0;
      err_mem_p5             <= 1'b0;
      pc_p5                  <= 16'h0000;
    end else begin
      state                  <= state_n;
      op_q                   <= op_n;
      cnt                    <= cnt_n;
      dmem_req               <= req_n;
      dmem_we                <= we_n;
      dmem_addr              <= addr_n;
      dmem_wdata             <= wdata_n;
      wb_value_mewb_p5       <= wb_val_n;
      wb_index_mewb_p5       <= wb_idx_n;
      wb_write_valid_mewb_p5 <= wb_wv_n;
      err_mem_p5             <= err_n;
      pc_p5                  <= pc5_n;
    end
  end

endmodule
